// File: rtl/pace_pkg.sv
// Shared types and constants for the PACE feed-path controllers.
package pace_pkg;

    localparam int unsigned PACE_NUM_STREAMS = 2;
    localparam int unsigned PACE_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pace_feed_state_e;

    typedef struct packed {
        logic [PACE_CNT_WIDTH-1:0] len;
    } pace_feed_cfg_t;

endpackage

// File: rtl/pace_credit_cnt.sv
// Saturating up/down credit counter; an increment and a decrement in the
// same cycle cancel. Reusable for any credit window starting full.
module pace_credit_cnt #(
    parameter int unsigned Max   = 2,
    parameter int unsigned Width = $clog2(Max + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             inc,
    input  logic             dec,
    output logic [Width-1:0] count
);

    localparam logic [Width-1:0] MaxVal  = Width'(Max);
    localparam logic [Width-1:0] ZeroVal = {Width{1'b0}};
    localparam logic [Width-1:0] OneVal  = Width'(1'b1);

    logic [Width-1:0] count_r;
    logic [Width-1:0] count_s;

    // Next count: single events move by one and stop at either bound.
    always_comb begin
        count_s = count_r;
        if (inc && !dec) begin
            if (count_r != MaxVal) begin
                count_s = count_r + OneVal;
            end else begin
                count_s = count_r;
            end
        end else if (dec && !inc) begin
            if (count_r != ZeroVal) begin
                count_s = count_r - OneVal;
            end else begin
                count_s = count_r;
            end
        end else begin
            count_s = count_r;
        end
    end

    // Count register; both resets refill the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= MaxVal;
        end else if (srst) begin
            count_r <= MaxVal;
        end else begin
            count_r <= count_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pace_feed_ctrl_chk.sv
// Property checker for pace_feed_ctrl: credit window bounds and beats
// offered while no job is active.
module pace_feed_ctrl_chk #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned CredWidth      = $clog2(MaxOutstanding + 1)
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic [CredWidth-1:0] credits,
    input logic                 cred_inc,
    input logic                 cred_dec,
    input logic                 beat_offered,
    input logic                 busy
);

    localparam logic [CredWidth-1:0] CredMax  = CredWidth'(MaxOutstanding);
    localparam logic [CredWidth-1:0] CredZero = {CredWidth{1'b0}};

    credit_range_a: assert property (@(posedge clk) disable iff (!rst_n)
        credits <= CredMax);

    credit_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(cred_dec && !cred_inc && (credits == CredZero)));

    credit_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(cred_inc && !cred_dec && (credits == CredMax)));

    beat_outside_job_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(beat_offered && !busy));

endmodule

// File: rtl/pace_feed_ctrl.sv
// Sequencing controller for the PACE wide-input feed path: credit-bounded
// word fetch requests, narrow-beat accounting and job-complete pulse.
module pace_feed_ctrl
    import pace_pkg::*;
#(
    parameter int unsigned NumStreams     = PACE_NUM_STREAMS,
    parameter int unsigned CntWidth       = PACE_CNT_WIDTH,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [CntWidth-1:0]           len_i,
    input  logic                          pause_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          req_valid_o,
    input  logic                          req_ready_i,
    input  logic                          beat_valid_i,
    input  logic                          beat_ready_i,
    output logic                          enable_o,
    output logic                          beat_last_o,
    output logic [$clog2(NumStreams)-1:0] beat_idx_o
);

    localparam int unsigned IdxWidth  = $clog2(NumStreams);
    localparam int unsigned BeatWidth = CntWidth + IdxWidth;
    localparam int unsigned CredWidth = $clog2(MaxOutstanding + 1);

    localparam logic [IdxWidth-1:0]  LastIdx   = IdxWidth'(NumStreams - 1);
    localparam logic [CntWidth-1:0]  CntZero   = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0]  CntOne    = CntWidth'(1'b1);
    localparam logic [BeatWidth-1:0] BeatZero  = {BeatWidth{1'b0}};
    localparam logic [BeatWidth-1:0] BeatOne   = BeatWidth'(1'b1);
    localparam logic [CredWidth-1:0] CredZero  = {CredWidth{1'b0}};

    pace_feed_state_e       state_r;
    pace_feed_state_e       state_s;
    pace_feed_cfg_t         cfg_r;
    logic [CntWidth-1:0]    len_s;
    logic [CntWidth-1:0]    req_cnt_r;
    logic [BeatWidth-1:0]   beat_cnt_r;
    logic [BeatWidth-1:0]   beat_total_s;
    logic [CredWidth-1:0]   credits_s;
    logic                   busy_s;
    logic                   start_ok_s;
    logic                   req_valid_s;
    logic                   req_fire_s;
    logic                   last_req_s;
    logic                   enable_s;
    logic                   beat_fire_s;
    logic                   last_beat_s;
    logic                   word_done_s;

    assign len_s        = CntWidth'(cfg_r.len);
    // NumStreams is a power of two, so the job's beat total is a shift.
    assign beat_total_s = {len_s, {IdxWidth{1'b0}}};

    assign busy_s      = (state_r == RUN) || (state_r == DRAIN);
    assign start_ok_s  = (state_r == IDLE) && start_i;
    assign req_valid_s = (state_r == RUN) && (req_cnt_r < len_s) && (credits_s != CredZero);
    assign req_fire_s  = req_valid_s && req_ready_i;
    assign last_req_s  = (req_cnt_r == (len_s - CntOne));
    assign enable_s    = busy_s && !pause_i;
    assign beat_fire_s = beat_valid_i && beat_ready_i && enable_s;
    assign last_beat_s = (beat_cnt_r == (beat_total_s - BeatOne));
    assign word_done_s = beat_fire_s && (beat_cnt_r[IdxWidth-1:0] == LastIdx);

    // Next-state decode for the job sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if (len_i != CntZero) begin
                        state_s = RUN;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (req_fire_s && last_req_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (beat_fire_s && last_beat_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register; soft clear aborts any job straight back to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else if (clear_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job length latch plus request and beat counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_r      <= '{len: {PACE_CNT_WIDTH{1'b0}}};
            req_cnt_r  <= CntZero;
            beat_cnt_r <= BeatZero;
        end else if (clear_i) begin
            cfg_r      <= '{len: {PACE_CNT_WIDTH{1'b0}}};
            req_cnt_r  <= CntZero;
            beat_cnt_r <= BeatZero;
        end else if (start_ok_s) begin
            cfg_r.len  <= PACE_CNT_WIDTH'(len_i);
            req_cnt_r  <= CntZero;
            beat_cnt_r <= BeatZero;
        end else begin
            if (req_fire_s) begin
                req_cnt_r <= req_cnt_r + CntOne;
            end
            if (beat_fire_s) begin
                beat_cnt_r <= beat_cnt_r + BeatOne;
            end
        end
    end

    pace_credit_cnt #(
        .Max   (MaxOutstanding),
        .Width (CredWidth)
    ) u_credits (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .srst  (clear_i),
        .inc   (word_done_s),
        .dec   (req_fire_s),
        .count (credits_s)
    );

    pace_feed_ctrl_chk #(
        .MaxOutstanding (MaxOutstanding),
        .CredWidth      (CredWidth)
    ) u_chk (
        .clk          (clk_i),
        .rst_n        (rst_ni),
        .credits      (credits_s),
        .cred_inc     (word_done_s),
        .cred_dec     (req_fire_s),
        .beat_offered (beat_valid_i && beat_ready_i),
        .busy         (busy_s)
    );

    assign busy_o      = busy_s;
    assign done_o      = (state_r == DONE);
    assign req_valid_o = req_valid_s;
    assign enable_o    = enable_s;
    assign beat_last_o = busy_s && last_beat_s;
    assign beat_idx_o  = beat_cnt_r[IdxWidth-1:0];

endmodule
